// File: rtl/inst_fetch_unit_if.sv
// Icache request/response channel between the fetch unit (master) and the icache (slave).
// One request may be outstanding; responses return in order, one per accepted request.
interface inst_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            ic_req_valid;
  logic [XLEN-1:0] ic_req_addr;
  logic            ic_req_ready;
  logic            ic_resp_valid;
  logic [31:0]     ic_resp_inst;

  modport master (
    output ic_req_valid,
    output ic_req_addr,
    input  ic_req_ready,
    input  ic_resp_valid,
    input  ic_resp_inst
  );

  modport slave (
    input  ic_req_valid,
    input  ic_req_addr,
    output ic_req_ready,
    output ic_resp_valid,
    output ic_resp_inst
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Fetch front end: PC generation, single-outstanding icache requests, JAL/JALR predecode,
// redirect flush with stale-response drop, and an IQ_DEPTH-entry queue feeding decode.
module inst_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              IQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  inst_fetch_unit_if.master ic,
  output logic [XLEN-1:0] bp_query_pc,
  input  logic            bp_taken,
  input  logic [XLEN-1:0] bp_target,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            jalr_done,
  input  logic [XLEN-1:0] jalr_target,
  output logic            out_valid,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_pred_taken,
  input  logic            out_ready
);

  localparam int PW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int CW = $clog2(IQ_DEPTH + 1);

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT       = 2'd1,
    S_STALL_JALR = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            drop_reg, drop_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg, count_next;

  logic [31:0]     inst_mem  [IQ_DEPTH];
  logic [XLEN-1:0] pc_mem    [IQ_DEPTH];
  logic            taken_mem [IQ_DEPTH];

  logic            req_fire;
  logic            deq;
  logic            enq;
  logic            enq_taken;
  logic            is_jal;
  logic            is_jalr;
  logic [XLEN-1:0] jal_offset;

  assign ic.ic_req_valid = !rst_in && (state_reg == S_IDLE) && (count_reg < CW'(IQ_DEPTH));
  assign ic.ic_req_addr  = pc_reg;
  assign bp_query_pc     = pc_reg;

  assign out_valid      = !rst_in && (count_reg != '0);
  assign out_inst       = inst_mem[rd_ptr_reg];
  assign out_pc         = pc_mem[rd_ptr_reg];
  assign out_pred_taken = taken_mem[rd_ptr_reg];

  assign req_fire = ic.ic_req_valid && ic.ic_req_ready;
  assign deq      = out_valid && out_ready;

  assign is_jal     = (ic.ic_resp_inst[6:0] == OPC_JAL);
  assign is_jalr    = (ic.ic_resp_inst[6:0] == OPC_JALR);
  assign jal_offset = {{(XLEN-20){ic.ic_resp_inst[31]}}, ic.ic_resp_inst[19:12],
                       ic.ic_resp_inst[20], ic.ic_resp_inst[30:21], 1'b0};

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    drop_next   = drop_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    enq         = 1'b0;
    enq_taken   = 1'b0;

    if (redirect_valid) begin
      pc_next     = redirect_pc;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
      // A request still owed a response (including one accepted this very cycle)
      // must have that response thrown away when it finally arrives.
      if (state_reg == S_WAIT && !ic.ic_resp_valid) begin
        state_next = S_WAIT;
        drop_next  = 1'b1;
      end else if (state_reg == S_IDLE && req_fire) begin
        state_next = S_WAIT;
        drop_next  = 1'b1;
      end else begin
        state_next = S_IDLE;
        drop_next  = 1'b0;
      end
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (req_fire) begin
            state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          if (ic.ic_resp_valid) begin
            if (drop_reg) begin
              drop_next  = 1'b0;
              state_next = S_IDLE;
            end else begin
              enq        = 1'b1;
              state_next = S_IDLE;
              if (is_jal) begin
                pc_next   = pc_reg + jal_offset;
                enq_taken = 1'b1;
              end else if (is_jalr) begin
                state_next = S_STALL_JALR;
              end else if (bp_taken) begin
                pc_next   = bp_target;
                enq_taken = 1'b1;
              end else begin
                pc_next = pc_reg + XLEN'(4);
              end
            end
          end
        end
        S_STALL_JALR: begin
          if (jalr_done) begin
            pc_next    = jalr_target;
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase

      if (enq) begin
        wr_ptr_next = wr_ptr_reg + PW'(1);
      end
      if (deq) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      count_next = count_reg + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg  <= S_IDLE;
      pc_reg     <= RESET_PC;
      drop_reg   <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (rdy_in) begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      drop_reg   <= drop_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Queue storage carries no reset; occupancy is tracked solely by count_reg.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && enq) begin
      inst_mem[wr_ptr_reg]  <= ic.ic_resp_inst;
      pc_mem[wr_ptr_reg]    <= pc_reg;
      taken_mem[wr_ptr_reg] <= enq_taken;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized and directed bench for inst_fetch_unit against a queue-based behavioural model.
module tb_inst_fetch_unit;
  localparam int          XLEN = 32;
  localparam int          D    = 4;
  localparam logic [31:0] RPC  = 32'h100;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        taken;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, rdy, redirect_valid, jalr_done, out_ready, bp_taken;
  logic [31:0] redirect_pc, jalr_target, bp_target;
  logic [31:0] bp_query_pc, out_inst, out_pc;
  logic        out_valid, out_pred_taken;

  always #5 clk = ~clk;

  inst_fetch_unit_if #(.XLEN(XLEN)) ic ();

  inst_fetch_unit #(.XLEN(XLEN), .IQ_DEPTH(D), .RESET_PC(RPC)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .rdy_in        (rdy),
    .ic            (ic),
    .bp_query_pc   (bp_query_pc),
    .bp_taken      (bp_taken),
    .bp_target     (bp_target),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .jalr_done     (jalr_done),
    .jalr_target   (jalr_target),
    .out_valid     (out_valid),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_pred_taken(out_pred_taken),
    .out_ready     (out_ready)
  );

  // Reference model: mode 0=idle, 1=waiting for response, 2=stalled on JALR
  int          m_mode;
  logic [31:0] m_pc;
  bit          m_drop;
  ent_t        m_q[$];

  // Icache model
  bit          ic_pend;
  int          ic_delay;
  logic [31:0] ic_inst;
  int          delay_fixed;
  bit          delay_rand;
  bit          rand_prog;
  logic [31:0] mem[logic [31:0]];

  int          checks;
  int          failures;
  logic [31:0] fire_log[$];
  ent_t        deq_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] jal_off(input logic [31:0] i);
    logic [31:0] o;
    o = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    return o;
  endfunction

  function automatic logic [31:0] rand_inst();
    int r;
    r = $urandom_range(99, 0);
    if (r < 55)      return ($urandom & 32'hFFFF_FF80) | 32'h13;
    else if (r < 75) return ($urandom & 32'hFFFF_F000) | 32'h0000_00EF;
    else if (r < 85) return ($urandom & 32'hFFF0_0000) | 32'h0000_80E7;
    else             return $urandom;
  endfunction

  task automatic cycle();
    bit          e_req, e_ov, fire, deq, resp;
    logic [31:0] fire_addr;
    ent_t        e;
    ic.ic_resp_valid = ic_pend && (ic_delay == 0);
    ic.ic_resp_inst  = ic_pend ? ic_inst : 32'h0;
    #1;
    e_req = !rst && m_mode == 0 && m_q.size() < D;
    e_ov  = !rst && m_q.size() > 0;
    check("req_valid", {31'b0, ic.ic_req_valid}, {31'b0, e_req});
    if (e_req) check("req_addr", ic.ic_req_addr, m_pc);
    if (!rst && m_mode == 1) check("bp_query_pc", bp_query_pc, m_pc);
    check("out_valid", {31'b0, out_valid}, {31'b0, e_ov});
    if (e_ov) begin
      check("out_pc", out_pc, m_q[0].pc);
      check("out_inst", out_inst, m_q[0].inst);
      check("out_pred_taken", {31'b0, out_pred_taken}, {31'b0, m_q[0].taken});
    end
    if (ic.ic_req_valid && ic.ic_req_ready && rdy && !rst) fire_log.push_back(ic.ic_req_addr);

    fire      = e_req && ic.ic_req_ready && rdy;
    deq       = e_ov && out_ready && rdy;
    resp      = !rst && m_mode == 1 && ic.ic_resp_valid;
    fire_addr = m_pc;
    if (deq) begin
      e.inst  = out_inst;
      e.pc    = out_pc;
      e.taken = out_pred_taken;
      deq_log.push_back(e);
      $display("deq pc=%h inst=%h taken=%0d", out_pc, out_inst, out_pred_taken);
    end

    if (rst) begin
      m_pc = RPC; m_q.delete(); m_mode = 0; m_drop = 0;
    end else if (rdy) begin
      if (redirect_valid) begin
        m_q.delete();
        m_pc = redirect_pc;
        if (m_mode == 1 && !resp) m_drop = 1;
        else if (fire) begin m_mode = 1; m_drop = 1; end
        else begin m_mode = 0; m_drop = 0; end
      end else begin
        if (deq) void'(m_q.pop_front());
        if (m_mode == 0) begin
          if (fire) m_mode = 1;
        end else if (m_mode == 1) begin
          if (resp) begin
            if (m_drop) begin
              m_drop = 0; m_mode = 0;
            end else begin
              e.inst = ic_inst;
              e.pc   = m_pc;
              m_mode = 0;
              if (ic_inst[6:0] == 7'b1101111) begin
                e.taken = 1; m_pc = m_pc + jal_off(ic_inst);
              end else if (ic_inst[6:0] == 7'b1100111) begin
                e.taken = 0; m_mode = 2;
              end else if (bp_taken) begin
                e.taken = 1; m_pc = bp_target;
              end else begin
                e.taken = 0; m_pc = m_pc + 4;
              end
              m_q.push_back(e);
            end
          end
        end else if (jalr_done) begin
          m_pc = jalr_target; m_mode = 0;
        end
      end
    end

    if (rst) begin
      ic_pend = 0;
    end else begin
      if (resp && rdy) ic_pend = 0;
      else if (ic_pend && ic_delay > 0) ic_delay--;
      if (fire) begin
        ic_pend  = 1;
        ic_delay = delay_rand ? $urandom_range(3, 0) : delay_fixed;
        if (mem.exists(fire_addr)) ic_inst = mem[fire_addr];
        else if (rand_prog)        ic_inst = rand_inst();
        else                       ic_inst = NOP;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst = 1;
    run(2);
    rst = 0;
    fire_log.delete();
    deq_log.delete();
  endtask

  task automatic redirect_to(input logic [31:0] a);
    ic.ic_req_ready = 0;
    redirect_valid  = 1;
    redirect_pc     = a;
    cycle();
    redirect_valid  = 0;
    ic.ic_req_ready = 1;
    fire_log.delete();
    deq_log.delete();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1; rdy = 1; redirect_valid = 0; jalr_done = 0; out_ready = 1; bp_taken = 0;
    redirect_pc = 0; jalr_target = 0; bp_target = 0;
    ic.ic_req_ready = 1; ic.ic_resp_valid = 0; ic.ic_resp_inst = 0;
    m_mode = 0; m_pc = RPC; m_drop = 0;
    ic_pend = 0; ic_delay = 0; ic_inst = NOP;
    delay_fixed = 0; delay_rand = 0; rand_prog = 0;
    mem[32'h200] = 32'h0200_00EF;  // jal x1, +0x20
    mem[32'h300] = 32'h0000_80E7;  // jalr x1, 0(x1)
    @(negedge clk);

    // Sequential NOP fetch from the reset PC
    do_reset();
    run(8);
    check("t1_fire0", fire_log[0], 32'h100);
    check("t1_fire1", fire_log[1], 32'h104);
    check("t1_fire2", fire_log[2], 32'h108);
    check("t1_taken0", {31'b0, deq_log[0].taken}, 32'h0);

    // Queue fills with decode stalled; one dequeue frees one request
    out_ready = 0;
    do_reset();
    run(20);
    check("t2_fires_full", fire_log.size(), 4);
    check("t2_req_blocked", {31'b0, ic.ic_req_valid}, 32'h0);
    out_ready = 1;
    cycle();
    out_ready = 0;
    run(10);
    check("t2_fires_after_deq", fire_log.size(), 5);

    // JAL predecode
    out_ready = 1;
    do_reset();
    redirect_to(32'h200);
    run(6);
    check("t3_fire_jal", fire_log[0], 32'h200);
    check("t3_fire_target", fire_log[1], 32'h220);
    check("t3_deq_pc", deq_log[0].pc, 32'h200);
    check("t3_deq_taken", {31'b0, deq_log[0].taken}, 32'h1);

    // JALR stall, resolution, and a late jalr_done being ignored
    do_reset();
    redirect_to(32'h300);
    run(8);
    check("t4_stall_fires", fire_log.size(), 1);
    check("t4_stall_req", {31'b0, ic.ic_req_valid}, 32'h0);
    jalr_done = 1; jalr_target = 32'h480;
    cycle();
    jalr_done = 0;
    cycle();
    jalr_done = 1; jalr_target = 32'h900;
    cycle();
    jalr_done = 0;
    run(4);
    check("t4_fire_target", fire_log[1], 32'h480);
    check("t4_fire_next", fire_log[2], 32'h484);
    check("t4_jalr_taken", {31'b0, deq_log[0].taken}, 32'h0);

    // Redirect while a slow response is outstanding
    delay_fixed = 3;
    out_ready   = 0;
    do_reset();
    for (int i = 0; i < 50 && fire_log.size() < 3; i++) cycle();
    check("t5_reach_wait", fire_log.size(), 3);
    redirect_valid = 1; redirect_pc = 32'h600;
    cycle();
    redirect_valid = 0;
    check("t5_flushed", {31'b0, out_valid}, 32'h0);
    run(20);
    check("t5_restart", fire_log[3], 32'h600);
    check("t5_head_pc", out_pc, 32'h600);

    // Global stall with a response held on the bus
    delay_fixed = 0;
    do_reset();
    cycle();
    rdy = 0;
    run(3);
    check("t6_frozen_fires", fire_log.size(), 1);
    check("t6_frozen_out", {31'b0, out_valid}, 32'h0);
    rdy = 1;
    cycle();
    check("t6_resp_taken", {31'b0, out_valid}, 32'h1);
    check("t6_head_pc", out_pc, 32'h100);
    run(20);
    check("t6_total_fires", fire_log.size(), 4);
    check("t6_full_block", {31'b0, ic.ic_req_valid}, 32'h0);

    // Random traffic
    mem.delete();
    rand_prog  = 1;
    delay_rand = 1;
    out_ready  = 1;
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      rst             = ($urandom_range(199, 0) == 0);
      rdy             = ($urandom_range(9, 0) != 0);
      ic.ic_req_ready = ($urandom_range(9, 0) < 7);
      out_ready       = ($urandom_range(9, 0) < 6);
      redirect_valid  = ($urandom_range(24, 0) == 0);
      redirect_pc     = $urandom & 32'hFFFF_FFFC;
      jalr_done       = ($urandom_range(7, 0) == 0);
      jalr_target     = $urandom & 32'hFFFF_FFFC;
      bp_taken        = ($urandom_range(4, 0) == 0);
      bp_target       = $urandom & 32'hFFFF_FFFC;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
